// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 800x600@72 timing, derived totals,
// sync windows, the packed RGB triple and a small window-test helper.
package vga_pkg;

   localparam int unsigned VGA_H_VISIBLE = 800;
   localparam int unsigned VGA_H_FRONT   = 56;
   localparam int unsigned VGA_H_SYNC    = 120;
   localparam int unsigned VGA_H_BACK    = 64;
   localparam int unsigned VGA_V_VISIBLE = 600;
   localparam int unsigned VGA_V_FRONT   = 37;
   localparam int unsigned VGA_V_SYNC    = 6;
   localparam int unsigned VGA_V_BACK    = 23;
   localparam logic        VGA_SYNC_POL  = 1'b1;
   localparam int unsigned VGA_PIX_DIV   = 1;

   localparam int unsigned VGA_H_TOTAL =
      VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int unsigned VGA_V_TOTAL =
      VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
   localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
   localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
   localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

   // 12-bit colour as produced by the console and driven to the VGA pins.
   typedef struct packed {
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } vga_rgb_t;

   // True when cnt lies in the half-open window [lo, hi). 12 bits so that a
   // window ending exactly at 2048 still compares correctly.
   function automatic logic in_span(input logic [11:0] cnt,
                                    input logic [11:0] lo,
                                    input logic [11:0] hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: counts 0..PIX_DIV-1 and strobes pix_tick on the last
// count. The strobe is gated by reset so it drops as soon as reset asserts.
module vga_pix_div #(
   parameter int unsigned PIX_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic pix_tick
);

   localparam int unsigned DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

   logic [DW-1:0] div;

   // Free-running modulo-PIX_DIV counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign pix_tick = ~rst & (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel counters, registered coordinates/display
// enable/frame pulse (stage 1), and blanked RGB plus syncs aligned one pixel
// later (stage 2).
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
   parameter int unsigned H_FRONT   = VGA_H_FRONT,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BACK    = VGA_H_BACK,
   parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
   parameter int unsigned V_FRONT   = VGA_V_FRONT,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BACK    = VGA_V_BACK,
   parameter logic        SYNC_POL  = VGA_SYNC_POL,
   parameter int unsigned PIX_DIV   = VGA_PIX_DIV
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [3:0]  i_red,
   input  logic [3:0]  i_green,
   input  logic [3:0]  i_blue,
   output logic        o_pix_tick,
   output logic [10:0] o_h_coord,
   output logic [9:0]  o_v_coord,
   output logic        o_disp_enbl,
   output logic        o_frame_start,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic [3:0]  o_vga_r,
   output logic [3:0]  o_vga_g,
   output logic [3:0]  o_vga_b
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [11:0] H_VIS_W    = 12'(H_VISIBLE);
   localparam logic [11:0] V_VIS_W    = 12'(V_VISIBLE);
   localparam logic [11:0] HS_START_W = 12'(H_VISIBLE + H_FRONT);
   localparam logic [11:0] HS_END_W   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [11:0] VS_START_W = 12'(V_VISIBLE + V_FRONT);
   localparam logic [11:0] VS_END_W   = 12'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

   if (H_TOTAL > 2048) begin : g_chk_h_total
      $error("vga_timing_gen: H_TOTAL exceeds 2048");
   end
   if (V_TOTAL > 1024) begin : g_chk_v_total
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
   end
   if (PIX_DIV < 1) begin : g_chk_pix_div
      $error("vga_timing_gen: PIX_DIV must be at least 1");
   end

   logic [1:0]  rst_sync;
   logic        rst;
   logic        pix_tick;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic        hs1;
   logic        vs1;
   logic        frame_start_q;
   vga_rgb_t    rgb_in;
   vga_rgb_t    rgb_q;

   assign rgb_in = '{red: i_red, green: i_green, blue: i_blue};

   // Reset bridge: assert immediately with arst, release on the second clk.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rst_sync <= '1;
      end else begin
         rst_sync <= {rst_sync[0], 1'b0};
      end
   end

   assign rst = rst_sync[1];

   vga_pix_div #(
      .PIX_DIV (PIX_DIV)
   ) u_pix_div (
      .clk      (clk),
      .rst      (rst),
      .pix_tick (pix_tick)
   );

   assign o_pix_tick = pix_tick;

   // Raster counters: h wraps each line, v steps on h wrap and wraps each frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 1'b1;
            end
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Stage 1: publish the pre-increment counters and decode enable/sync windows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_h_coord   <= '0;
         o_v_coord   <= '0;
         o_disp_enbl <= 1'b0;
         hs1         <= 1'b0;
         vs1         <= 1'b0;
      end else if (pix_tick) begin
         o_h_coord   <= h_cnt;
         o_v_coord   <= v_cnt;
         o_disp_enbl <= ({1'b0, h_cnt} < H_VIS_W) && ({2'b00, v_cnt} < V_VIS_W);
         hs1         <= in_span({1'b0, h_cnt}, HS_START_W, HS_END_W);
         vs1         <= in_span({2'b00, v_cnt}, VS_START_W, VS_END_W);
      end
   end

   // Frame pulse lasts one clk, covering the cycle in which (0,0) is first shown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= pix_tick && (h_cnt == '0) && (v_cnt == '0);
      end
   end

   assign o_frame_start = frame_start_q;

   // Stage 2: blank the console colour and polarise the syncs, one pixel behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q   <= '0;
         o_hsync <= ~SYNC_POL;
         o_vsync <= ~SYNC_POL;
      end else if (pix_tick) begin
         rgb_q   <= o_disp_enbl ? rgb_in : '0;
         o_hsync <= hs1 ^ ~SYNC_POL;
         o_vsync <= vs1 ^ ~SYNC_POL;
      end
   end

   assign o_vga_r = rgb_q.red;
   assign o_vga_g = rgb_q.green;
   assign o_vga_b = rgb_q.blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two scaled-down instances
// (PIX_DIV=1/active-high syncs and PIX_DIV=2/active-low syncs). The stimulus
// side predicts every pixel from its index in the raster and queues it; the
// monitor pops and compares each time the DUT strobes o_pix_tick.
module tb_vga_timing_gen;

   localparam int unsigned HV = 16;
   localparam int unsigned HF = 4;
   localparam int unsigned HS = 6;
   localparam int unsigned HB = 4;
   localparam int unsigned VV = 10;
   localparam int unsigned VF = 2;
   localparam int unsigned VS = 3;
   localparam int unsigned VB = 2;
   localparam int unsigned HT = HV + HF + HS + HB;
   localparam int unsigned VT = VV + VF + VS + VB;
   localparam int unsigned FRAME = HT * VT;

   typedef struct {
      int unsigned cyc;
      logic [10:0] h;
      logic [9:0]  v;
      logic        de;
      logic        fs;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } exp_t;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int unsigned inst,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d at cycle %0d: got %0h, expected %0h",
                  name, inst, cyc, act, exp);
      end
   endtask

   // Reference raster: pixel n since reset sits at (n mod frame) in row-major order.
   function automatic int unsigned px_h(input int unsigned n);
      return (n % FRAME) % HT;
   endfunction

   function automatic int unsigned px_v(input int unsigned n);
      return (n % FRAME) / HT;
   endfunction

   function automatic logic px_vis(input int unsigned n);
      return (px_h(n) < HV) && (px_v(n) < VV);
   endfunction

   function automatic logic px_hwin(input int unsigned n);
      return (px_h(n) >= HV + HF) && (px_h(n) < HV + HF + HS);
   endfunction

   function automatic logic px_vwin(input int unsigned n);
      return (px_v(n) >= VV + VF) && (px_v(n) < VV + VF + VS);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int unsigned PD = (g == 0) ? 1 : 2;
      localparam logic SP   = (g == 0) ? 1'b1 : 1'b0;
      localparam logic IDLE = ~SP;

      logic        arst;
      logic [11:0] rgb_in;
      logic        pix_tick;
      logic [10:0] h;
      logic [9:0]  v;
      logic        de;
      logic        fs;
      logic        hs;
      logic        vs;
      logic [3:0]  vr;
      logic [3:0]  vg;
      logic [3:0]  vb;
      logic        done;
      exp_t        q[$];

      vga_timing_gen #(
         .H_VISIBLE (HV),
         .H_FRONT   (HF),
         .H_SYNC    (HS),
         .H_BACK    (HB),
         .V_VISIBLE (VV),
         .V_FRONT   (VF),
         .V_SYNC    (VS),
         .V_BACK    (VB),
         .SYNC_POL  (SP),
         .PIX_DIV   (PD)
      ) dut (
         .clk           (clk),
         .arst          (arst),
         .i_red         (rgb_in[11:8]),
         .i_green       (rgb_in[7:4]),
         .i_blue        (rgb_in[3:0]),
         .o_pix_tick    (pix_tick),
         .o_h_coord     (h),
         .o_v_coord     (v),
         .o_disp_enbl   (de),
         .o_frame_start (fs),
         .o_hsync       (hs),
         .o_vsync       (vs),
         .o_vga_r       (vr),
         .o_vga_g       (vg),
         .o_vga_b       (vb)
      );

      task automatic check_idle();
         chk("idle_tick", g, pix_tick, 1'b0);
         chk("idle_h", g, h, 11'd0);
         chk("idle_v", g, v, 10'd0);
         chk("idle_de", g, de, 1'b0);
         chk("idle_fs", g, fs, 1'b0);
         chk("idle_hsync", g, hs, IDLE);
         chk("idle_vsync", g, vs, IDLE);
         chk("idle_rgb", g, {vr, vg, vb}, 12'h000);
         chk("idle_queue_drained", g, q.size(), 0);
      endtask

      // Release reset, align to the first tick, queue nt predicted pixels, then
      // reassert reset (asynchronously, between edges) at the next tick.
      task automatic run(input int unsigned nt);
         exp_t        e;
         logic [11:0] px;
         int unsigned wd;
         arst = 1'b0;
         wd = 0;
         while (!pix_tick && wd < 16) begin
            rgb_in = 12'hFFF;
            @(negedge clk);
            wd++;
         end
         chk("first_tick_seen", g, pix_tick, 1'b1);
         for (int unsigned n = 0; n < nt; n++) begin
            px = (n < FRAME) ? 12'hFFF : 12'($urandom);
            rgb_in = px;
            e.cyc = cyc;
            e.h   = 11'(px_h(n));
            e.v   = 10'(px_v(n));
            e.de  = px_vis(n);
            e.fs  = (n % FRAME) == 0;
            if (n == 0) begin
               e.hs  = IDLE;
               e.vs  = IDLE;
               e.rgb = 12'h000;
            end else begin
               e.hs  = px_hwin(n - 1) ? SP : IDLE;
               e.vs  = px_vwin(n - 1) ? SP : IDLE;
               e.rgb = px_vis(n - 1) ? px : 12'h000;
            end
            q.push_back(e);
            for (int unsigned k = 1; k < PD; k++) begin
               @(negedge clk);
               rgb_in = (n < FRAME) ? 12'hFFF : 12'($urandom);
            end
            @(negedge clk);
         end
         #1 arst = 1'b1;
         #1 check_idle();
      endtask

      initial begin : stim
         arst = 1'b1;
         rgb_in = '0;
         done = 1'b0;
         repeat (4) @(negedge clk);
         #1 check_idle();
         @(negedge clk);
         // Two full frames plus a partial one, ending with stage 1 at (8,5).
         run(2 * FRAME + 5 * HT + 9);
         repeat (3) @(negedge clk);
         #1 check_idle();
         @(negedge clk);
         run(40);
         done = 1'b1;
      end

      initial begin : mon
         exp_t        e;
         logic        seen;
         int unsigned seen_cyc;
         seen = 1'b0;
         seen_cyc = 0;
         forever begin
            @(negedge clk);
            if (seen) begin
               chk("exp_available", g, 32'(q.size() != 0), 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("tick_cycle", g, seen_cyc, e.cyc);
                  chk("h_coord", g, h, e.h);
                  chk("v_coord", g, v, e.v);
                  chk("disp_enbl", g, de, e.de);
                  chk("frame_start", g, fs, e.fs);
                  chk("hsync", g, hs, e.hs);
                  chk("vsync", g, vs, e.vs);
                  chk("vga_rgb", g, {vr, vg, vb}, e.rgb);
               end
            end else begin
               chk("frame_start_quiet", g, fs, 1'b0);
            end
            #3;
            seen = pix_tick;
            seen_cyc = cyc;
         end
      end
   end

   initial begin : supervisor
      for (int i = 0; i < 20000; i++) begin
         if (u[0].done && u[1].done) break;
         @(posedge clk);
      end
      checks++;
      if (!(u[0].done && u[1].done)) begin
         errors++;
         $display("FAIL completion: stimulus still running after 20000 cycles, expected done");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
